// File: rtl/corr_out_arbiter.sv
// Round-robin arbiter sharing one result output register between NCH correlator channels.
// Optional macro DROP_CNT_EN adds a saturating 16-bit dropped-sample counter port (drop_cnt).
module corr_out_arbiter #(
  parameter int NCH = 4,
  parameter int W   = 14,
  parameter int CHW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [NCH-1:0]   det,
  input  logic [NCH*W-1:0] din,
  input  logic             clr_ovr,
  input  logic             out_ready,
  output logic             out_val,
  output logic [W-1:0]     out_data,
  output logic [CHW-1:0]   out_ch,
  output logic [NCH-1:0]   overrun
`ifdef DROP_CNT_EN
  ,
  output logic [15:0]      drop_cnt
`endif
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t         state_q;
  logic [W-1:0]   pend_q [NCH];
  logic [NCH-1:0] pendV_q, pendV_d;
  logic [CHW-1:0] rrLast_q;
  logic           outVal_q;
  logic [W-1:0]   outData_q;
  logic [CHW-1:0] outCh_q;
  logic [NCH-1:0] overrun_q, overrun_d;

  logic [CHW-1:0] grantIdx;
  logic           grantFound;
  logic           grantFire;
  logic [NCH-1:0] grantMask;
  logic [NCH-1:0] captureMask;
  logic [NCH-1:0] collideMask;
  int             candIdx;

  // Search upward from the channel after the last grant, wrapping modulo NCH.
  always_comb begin
    grantIdx   = '0;
    grantFound = 1'b0;
    candIdx    = 0;
    for (int k = 1; k <= NCH; k++) begin
      candIdx = int'(rrLast_q) + k;
      if (candIdx >= NCH) candIdx = candIdx - NCH;
      if (!grantFound && pendV_q[candIdx]) begin
        grantFound = 1'b1;
        grantIdx   = CHW'(candIdx);
      end
    end
  end

  always_comb begin
    grantFire   = grantFound && ((state_q == IDLE) || out_ready);
    grantMask   = grantFire ? (NCH'(1) << grantIdx) : '0;
    // A slot being granted this cycle may be refilled in the same cycle.
    captureMask = det & (~pendV_q | grantMask);
    collideMask = det & pendV_q & ~grantMask;
    pendV_d     = (pendV_q & ~grantMask) | captureMask;
    overrun_d   = (clr_ovr ? '0 : overrun_q) | collideMask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pendV_q   <= '0;
      rrLast_q  <= CHW'(NCH - 1);
      outVal_q  <= 1'b0;
      outData_q <= '0;
      outCh_q   <= '0;
      overrun_q <= '0;
      for (int i = 0; i < NCH; i++) pend_q[i] <= '0;
    end else if (ena) begin
      pendV_q   <= pendV_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < NCH; i++) begin
        if (captureMask[i]) pend_q[i] <= din[i*W +: W];
      end
      case (state_q)
        IDLE: begin
          if (grantFire) begin
            outData_q <= pend_q[grantIdx];
            outCh_q   <= grantIdx;
            outVal_q  <= 1'b1;
            rrLast_q  <= grantIdx;
            state_q   <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (grantFire) begin
              outData_q <= pend_q[grantIdx];
              outCh_q   <= grantIdx;
              rrLast_q  <= grantIdx;
            end else begin
              outVal_q <= 1'b0;
              state_q  <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DROP_CNT_EN
  logic [15:0] dropCnt_q, dropCnt_d;
  logic [15:0] dropInc;
  logic [16:0] dropSum;

  // Clearing restarts the count from this cycle's drops; the sum saturates.
  always_comb begin
    dropInc = '0;
    for (int i = 0; i < NCH; i++) dropInc = dropInc + 16'(collideMask[i]);
    dropSum   = {1'b0, (clr_ovr ? 16'h0000 : dropCnt_q)} + {1'b0, dropInc};
    dropCnt_d = dropSum[16] ? 16'hFFFF : dropSum[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dropCnt_q <= '0;
    end else if (ena) begin
      dropCnt_q <= dropCnt_d;
    end
  end

  assign drop_cnt = dropCnt_q;
`endif

  assign out_val  = outVal_q;
  assign out_data = outData_q;
  assign out_ch   = outCh_q;
  assign overrun  = overrun_q;

endmodule
